collision_scheduler: RTL

- Time-multiplexes one collision comparator across N sprite slots, testing each active slot against the player once per frame.
- Started by a frame tick. Fetches slot positions from the sprite position register file over a one-cycle-latency read port.
- Accumulates a per-slot hit bitmap, then commits it with a done pulse for the game-logic FSM.
- Sits between the sprite position store and the game-state controller.

---
 rtl/collision_scheduler_pkg.sv | 23 ++
 rtl/collision_scheduler_collide.sv | 28 ++
 rtl/collision_scheduler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/collision_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : collision_scheduler_pkg
// Description : Shared game constants and scheduler state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package collision_scheduler_pkg;

  // Width of a screen coordinate
  localparam int SCREEN_COORD_W = 10;

  // Largest per-axis distance that still counts as a collision (inclusive)
  localparam logic [SCREEN_COORD_W-1:0] HIT_DIST = 10'd20;

  // Scheduler states
  typedef logic [1:0] state_t;
  localparam state_t IDLE  = 2'd0;
  localparam state_t SCAN  = 2'd1;
  localparam state_t DRAIN = 2'd2;
  localparam state_t DONE  = 2'd3;

endpackage : collision_scheduler_pkg
`default_nettype wire

// File: rtl/collision_scheduler_collide.sv
`default_nettype none
// ============================================================================
// Module      : collision_scheduler_collide
// Description : Combinational box-distance comparator for two screen points.
// Revision    : 1.0 - initial release
// ============================================================================
module collision_scheduler_collide
  import collision_scheduler_pkg::*;
(
  input  logic [SCREEN_COORD_W-1:0] a_h,
  input  logic [SCREEN_COORD_W-1:0] a_v,
  input  logic [SCREEN_COORD_W-1:0] b_h,
  input  logic [SCREEN_COORD_W-1:0] b_v,
  output logic                      collision
);

  logic [SCREEN_COORD_W-1:0] dist_h;
  logic [SCREEN_COORD_W-1:0] dist_v;

  // Absolute per-axis distance (larger minus smaller, never wraps)
  always_comb begin
    dist_h    = (a_h >= b_h) ? (a_h - b_h) : (b_h - a_h);
    dist_v    = (a_v >= b_v) ? (a_v - b_v) : (b_v - a_v);
    collision = (dist_h <= HIT_DIST) && (dist_v <= HIT_DIST);
  end

endmodule : collision_scheduler_collide
`default_nettype wire

// File: rtl/collision_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : collision_scheduler
// Description : Per-frame scan of all sprite slots against the player using a
//               single time-shared comparator; commits a hit bitmap with done.
// Revision    : 1.0 - initial release
// ============================================================================
module collision_scheduler
  import collision_scheduler_pkg::*;
#(
  parameter int N_SLOTS = 16,
  parameter int IDX_W   = 4
)
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [SCREEN_COORD_W-1:0] player_h,
  input  logic [SCREEN_COORD_W-1:0] player_v,
  input  logic [N_SLOTS-1:0]        slot_valid,
  output logic                      rd_en,
  output logic [IDX_W-1:0]          rd_addr,
  input  logic [SCREEN_COORD_W-1:0] rd_h,
  input  logic [SCREEN_COORD_W-1:0] rd_v,
  output logic                      busy,
  output logic                      done,
  output logic [N_SLOTS-1:0]        hit_map,
  output logic                      any_hit,
  output logic [IDX_W-1:0]          first_hit_idx
);

  if (IDX_W != $clog2(N_SLOTS)) begin : g_idx_w_check
    $error("IDX_W must equal clog2(N_SLOTS)");
  end

  state_t                    state_q,    state_d;
  logic [IDX_W-1:0]          idx_q,      idx_d;
  logic [SCREEN_COORD_W-1:0] ph_q,       ph_d;
  logic [SCREEN_COORD_W-1:0] pv_q,       pv_d;
  logic [N_SLOTS-1:0]        valid_q,    valid_d;
  logic [N_SLOTS-1:0]        work_q,     work_d;
  logic                      cmp_pend_q, cmp_pend_d;
  logic [IDX_W-1:0]          cmp_idx_q,  cmp_idx_d;
  logic                      done_q,     done_d;
  logic [N_SLOTS-1:0]        hit_q,      hit_d;
  logic                      any_q,      any_d;
  logic [IDX_W-1:0]          first_q,    first_d;
  logic                      collide;

  // Lowest set bit of a hit map, 0 when empty
  function automatic logic [IDX_W-1:0] first_set(input logic [N_SLOTS-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (m[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  // Single comparator: player snapshot against the data returned for the slot
  // read in the previous cycle
  collision_scheduler_collide u_collide (
    .a_h       (ph_q),
    .a_v       (pv_q),
    .b_h       (rd_h),
    .b_v       (rd_v),
    .collision (collide)
  );

  // Next-state: scan sequencing, pipelined compare retire and result commit
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    ph_d       = ph_q;
    pv_d       = pv_q;
    valid_d    = valid_q;
    work_d     = work_q;
    cmp_pend_d = 1'b0;
    cmp_idx_d  = cmp_idx_q;
    done_d     = 1'b0;
    hit_d      = hit_q;
    any_d      = any_q;
    first_d    = first_q;

    // Only valid slots are ever read, so only they retire a compare; invalid
    // bits keep the zero written at scan start.
    if (cmp_pend_q) work_d[cmp_idx_q] = collide;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SCAN;
          idx_d   = '0;
          ph_d    = player_h;
          pv_d    = player_v;
          valid_d = slot_valid;
          work_d  = '0;
        end
      end
      SCAN: begin
        cmp_pend_d = valid_q[idx_q];
        cmp_idx_d  = idx_q;
        if (idx_q == IDX_W'(N_SLOTS - 1)) state_d = DRAIN;
        else                              idx_d   = idx_q + 1'b1;
      end
      DRAIN: begin
        // work_d already includes the last slot's compare
        state_d = DONE;
        done_d  = 1'b1;
        hit_d   = work_d;
        any_d   = |work_d;
        first_d = first_set(work_d);
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      ph_q       <= '0;
      pv_q       <= '0;
      valid_q    <= '0;
      work_q     <= '0;
      cmp_pend_q <= 1'b0;
      cmp_idx_q  <= '0;
      done_q     <= 1'b0;
      hit_q      <= '0;
      any_q      <= 1'b0;
      first_q    <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ph_q       <= ph_d;
      pv_q       <= pv_d;
      valid_q    <= valid_d;
      work_q     <= work_d;
      cmp_pend_q <= cmp_pend_d;
      cmp_idx_q  <= cmp_idx_d;
      done_q     <= done_d;
      hit_q      <= hit_d;
      any_q      <= any_d;
      first_q    <= first_d;
    end
  end

  // Output drive; rd_addr simply follows the scan index and holds afterwards
  always_comb begin
    rd_en         = (state_q == SCAN) && valid_q[idx_q];
    rd_addr       = idx_q;
    busy          = (state_q != IDLE);
    done          = done_q;
    hit_map       = hit_q;
    any_hit       = any_q;
    first_hit_idx = first_q;
  end

endmodule : collision_scheduler
`default_nettype wire
